el2_trace_buf: RTL and testbench
================================

EL2_TRACE_BUF -- requirements
Module: el2_trace_buf

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered trace packets; SHALL be a power of two in the range 2..16.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 trace_en  input  1  capture enable; when low, no packets SHALL be captured or counted as dropped.
REQ-005 trace_pkt  input  el2_trace_pkt_t  retired-instruction trace packet from the TLU; its trace_rv_i_valid_ip field qualifies capture.
REQ-006 tr_valid  output  1  beat available on tr_data.
REQ-007 tr_ready  input  1  sink accepts the beat; a transfer SHALL occur when tr_valid and tr_ready are both high.
REQ-008 tr_data  output  32  serialized beat.
REQ-009 tr_last  output  1  high on the final beat (beat 3) of a packet.
REQ-010 fifo_count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-011 overflow  output  1  sticky flag: at least one packet has been dropped since reset.

Function
REQ-012 Capture SHALL occur in a cycle where trace_en=1 and trace_pkt.trace_rv_i_valid_ip=1; at most one push per cycle.
REQ-013 Each entry SHALL store the address, insn, tval, exception, ecause, and interrupt fields, plus an 8-bit drop field.
REQ-014 On push, the drop field SHALL take the current value of the drop counter, and the counter SHALL clear to 0 in the same cycle.
REQ-015 Capture when full SHALL discard the packet, increment the drop counter saturating at 255, and set overflow.
REQ-016 Exception: a push while full SHALL be accepted if, in the same cycle, the head entry's last beat transfers.
REQ-017 The head entry SHALL be emitted as 4 beats, counted by a 2-bit beat counter.
REQ-018 Beat 0 (header) SHALL be {drop[7:0], 16'h0, interrupt, exception, ecause[4:0], 1'b1}.
REQ-019 Beats 1, 2, and 3 SHALL be address, insn, and tval respectively.
REQ-020 The beat counter SHALL advance only on a transfer and wrap from 3 to 0; the entry SHALL pop on the transfer of beat 3.
REQ-021 tr_valid SHALL be high whenever fifo_count is nonzero.
REQ-022 While tr_valid=1 and tr_ready=0, tr_data and tr_last SHALL hold stable.
REQ-023 Latency: a packet pushed into an empty buffer SHALL present beat 0 in the cycle after capture, with no combinational path from trace_pkt to tr_*.
REQ-024 With tr_ready held high, a packet SHALL drain in exactly 4 cycles, for a sustained throughput of one packet per 4 cycles.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; fifo_count SHALL increment on push-only, decrement on pop-only, and hold on simultaneous push and pop.
REQ-026 Deasserting trace_en SHALL NOT flush the buffer; buffered entries SHALL continue to drain.

Reset
REQ-027 With rst=1 at a clock edge, the following SHALL clear to 0: pointers, fifo_count, beat counter, drop counter, overflow, tr_valid, and tr_last.
REQ-028 tr_data SHALL reset to 32'h0.
REQ-029 Reset asserted mid-packet SHALL abandon the partial packet, with no further beats of it emitted.
REQ-030 A capture in the cycle where rst=1 SHALL be ignored.

Structure
REQ-031 el2_pkg SHALL gain the typedef el2_trace_hdr_t, a packed 32-bit struct for the beat-0 layout.
REQ-032 el2_pkg SHALL gain the constant TRACE_BEATS = 4.
REQ-033 The entry storage and pointers SHALL reside in one sub-module, el2_trace_fifo, parameterized by width and DEPTH.
REQ-034 The beat serializer and drop logic SHALL reside in el2_trace_buf.

Verification
REQ-035 Single packet (address=32'h8000_0010, insn=32'h0000_0013, tval=0, no exception), tr_ready=1: expect beats 32'h0000_0001, 32'h8000_0010, 32'h0000_0013, 32'h0, in 4 consecutive cycles, tr_last on the 4th.
REQ-036 Backpressure: hold tr_ready=0 for 5 cycles after beat 1 appears: expect tr_data stable at 32'h8000_0010, then the packet completes normally.
REQ-037 Overflow: DEPTH=4, tr_ready=0, capture 7 packets: expect fifo_count=4 and overflow=1; release tr_ready and capture one more: expect that packet's header drop field = 3.
REQ-038 Drop saturation: 300 captures while full: expect the next accepted header drop field = 8'hFF.
REQ-039 Full with simultaneous pop: fifo_count=4, beat 3 transfers in the same cycle as a capture: expect the capture accepted, fifo_count still 4, no drop.
REQ-040 Reset mid-packet: assert rst after beat 1 transfers: expect tr_valid=0, fifo_count=0, and overflow=0 next cycle; the next capture's header appears with drop=0.

Source files
------------

// File: rtl/el2_pkg.sv
// Shared EL2 types for the trace path: TLU trace packet, trace buffer entry and
// the beat-0 header layout emitted on the trace port.
package el2_pkg;

  localparam int TRACE_BEATS = 4;

  typedef struct packed {
    logic [31:0] trace_rv_i_insn_ip;
    logic [31:0] trace_rv_i_address_ip;
    logic        trace_rv_i_valid_ip;
    logic        trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic        trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } el2_trace_pkt_t;

  // Beat 0 of every packet; marker is always 1 so a sink can resynchronise.
  typedef struct packed {
    logic [7:0]  drop;
    logic [15:0] rsvd;
    logic        interrupt;
    logic        exception;
    logic [4:0]  ecause;
    logic        marker;
  } el2_trace_hdr_t;

  typedef struct packed {
    logic [7:0]  drop;
    logic        interrupt;
    logic        exception;
    logic [4:0]  ecause;
    logic [31:0] address;
    logic [31:0] insn;
    logic [31:0] tval;
  } el2_trace_entry_t;

  localparam int TRACE_ENTRY_W = $bits(el2_trace_entry_t);

  typedef enum logic [1:0] {
    BEAT_HDR  = 2'd0,
    BEAT_ADDR = 2'd1,
    BEAT_INSN = 2'd2,
    BEAT_TVAL = 2'd3
  } el2_trace_beat_e;

endpackage

// File: rtl/el2_trace_buf_if.sv
// Serialized trace output port: one 32-bit beat per transfer, tr_last on beat 3.
interface el2_trace_buf_if;
  // A beat transfers on a rising clk when tr_valid && tr_ready. Once tr_valid is
  // high it stays high, and tr_data/tr_last hold, until that beat transfers.
  logic        tr_valid;
  logic        tr_ready;
  logic [31:0] tr_data;
  logic        tr_last;

  modport master (output tr_valid, output tr_data, output tr_last, input tr_ready);
  modport slave  (input tr_valid, input tr_data, input tr_last, output tr_ready);
endinterface

// File: rtl/el2_trace_fifo.sv
// Entry storage for the trace buffer: power-of-two circular FIFO, no overflow
// protection (the caller never pushes into a full FIFO without a same-cycle pop).
module el2_trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic [W-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (i_pop && !i_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/el2_trace_buf.sv
// Retired-instruction trace buffer: captures TLU trace packets into a FIFO and
// serializes the head entry as four 32-bit beats, counting packets lost to a full FIFO.
module el2_trace_buf
  import el2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trace_en,
  input  el2_trace_pkt_t         trace_pkt,
  el2_trace_buf_if.master        tr,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output el2_trace_beat_e        dbg_beat
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("el2_trace_buf: DEPTH must be a power of two in 2..16");
  end

  el2_trace_beat_e  r_beat, w_beat_nxt;
  el2_trace_entry_t w_wr_entry, w_head;
  el2_trace_hdr_t   w_hdr;
  logic [CW-1:0]    w_count;
  logic [31:0]      w_beat_data;
  logic [7:0]       r_drop_cnt;
  logic             r_overflow;
  logic             w_capture, w_full, w_xfer, w_pop, w_push, w_drop;

  assign w_capture = trace_en && trace_pkt.trace_rv_i_valid_ip && !rst;
  assign w_full    = (w_count == FULL_CNT);
  assign w_xfer    = tr.tr_valid && tr.tr_ready;
  assign w_pop     = w_xfer && (r_beat == BEAT_TVAL);
  // The slot freed by a last-beat pop can take a capture in the same cycle.
  assign w_push    = w_capture && (!w_full || w_pop);
  assign w_drop    = w_capture && !w_push;

  assign w_wr_entry = '{drop:      r_drop_cnt,
                        interrupt: trace_pkt.trace_rv_i_interrupt_ip,
                        exception: trace_pkt.trace_rv_i_exception_ip,
                        ecause:    trace_pkt.trace_rv_i_ecause_ip,
                        address:   trace_pkt.trace_rv_i_address_ip,
                        insn:      trace_pkt.trace_rv_i_insn_ip,
                        tval:      trace_pkt.trace_rv_i_tval_ip};

  el2_trace_fifo #(.W(TRACE_ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wr_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) r_beat <= BEAT_HDR;
    else     r_beat <= w_beat_nxt;
  end

  always_comb begin
    w_beat_nxt  = r_beat;
    w_beat_data = '0;
    w_hdr       = '{drop: w_head.drop, rsvd: 16'h0, interrupt: w_head.interrupt,
                    exception: w_head.exception, ecause: w_head.ecause, marker: 1'b1};
    case (r_beat)
      BEAT_HDR: begin
        w_beat_data = w_hdr;
        if (w_xfer) w_beat_nxt = BEAT_ADDR;
      end
      BEAT_ADDR: begin
        w_beat_data = w_head.address;
        if (w_xfer) w_beat_nxt = BEAT_INSN;
      end
      BEAT_INSN: begin
        w_beat_data = w_head.insn;
        if (w_xfer) w_beat_nxt = BEAT_TVAL;
      end
      BEAT_TVAL: begin
        w_beat_data = w_head.tval;
        if (w_xfer) w_beat_nxt = BEAT_HDR;
      end
      default: w_beat_nxt = BEAT_HDR;
    endcase
  end

  // Drop counter saturates at 255; it is handed to the next accepted entry and cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (w_push) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
      r_overflow <= 1'b1;
    end
  end

  assign tr.tr_valid = (w_count != '0);
  assign tr.tr_data  = tr.tr_valid ? w_beat_data : 32'h0;
  assign tr.tr_last  = tr.tr_valid && (r_beat == BEAT_TVAL);
  assign fifo_count  = w_count;
  assign overflow    = r_overflow;
  assign dbg_beat    = r_beat;

endmodule

// File: tb/tb_el2_trace_buf.sv
// Directed bench for el2_trace_buf: a reference model predicts occupancy, beats
// and drop counts; expected beats queue up at capture and are compared at each transfer.
module tb_el2_trace_buf;
  import el2_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            trace_en;
  el2_trace_pkt_t  trace_pkt;
  logic [CW-1:0]   fifo_count;
  logic            overflow;
  el2_trace_beat_e dbg_beat;

  el2_trace_buf_if tr_if ();

  el2_trace_buf #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .trace_en   (trace_en),
    .trace_pkt  (trace_pkt),
    .tr         (tr_if),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .dbg_beat   (dbg_beat)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_count = 0;
  int          m_beat  = 0;
  int          m_drop  = 0;
  logic        m_ovf   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic el2_trace_pkt_t mk_pkt(input logic [31:0] a, input logic [31:0] i,
                                            input logic [31:0] t, input logic e,
                                            input logic [4:0] c, input logic n);
    el2_trace_pkt_t p;
    p = '0;
    p.trace_rv_i_valid_ip     = 1'b1;
    p.trace_rv_i_address_ip   = a;
    p.trace_rv_i_insn_ip      = i;
    p.trace_rv_i_tval_ip      = t;
    p.trace_rv_i_exception_ip = e;
    p.trace_rv_i_ecause_ip    = c;
    p.trace_rv_i_interrupt_ip = n;
    return p;
  endfunction

  // Check outputs at the negedge, advance one clock, update the model, return at negedge.
  task automatic cycle();
    logic        v, xfer, last, cap, acc, drp;
    logic [31:0] e;
    v = (m_count != 0);
    e = (v && exp_q.size() > 0) ? exp_q[0] : 32'h0;
    chk("fifo_count", 32'(fifo_count), 32'(m_count));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("tr_valid", 32'(tr_if.tr_valid), 32'(v));
    chk("tr_last", 32'(tr_if.tr_last), 32'(v && (m_beat == 3)));
    chk("tr_data", tr_if.tr_data, e);
    chk("beat", 32'(dbg_beat), 32'(v ? m_beat : 0));
    xfer = v && tr_if.tr_ready;
    last = xfer && (m_beat == 3);
    cap  = trace_en && trace_pkt.trace_rv_i_valid_ip && !rst;
    acc  = cap && ((m_count < DEPTH) || last);
    drp  = cap && !acc;
    @(posedge clk);
    if (rst) begin
      m_count = 0;
      m_beat  = 0;
      m_drop  = 0;
      m_ovf   = 1'b0;
      exp_q.delete();
    end else begin
      if (xfer) begin
        void'(exp_q.pop_front());
        m_beat = (m_beat + 1) % TRACE_BEATS;
        if (last) m_count--;
      end
      if (acc) begin
        exp_q.push_back({8'(m_drop), 16'h0, trace_pkt.trace_rv_i_interrupt_ip,
                         trace_pkt.trace_rv_i_exception_ip, trace_pkt.trace_rv_i_ecause_ip, 1'b1});
        exp_q.push_back(trace_pkt.trace_rv_i_address_ip);
        exp_q.push_back(trace_pkt.trace_rv_i_insn_ip);
        exp_q.push_back(trace_pkt.trace_rv_i_tval_ip);
        m_drop = 0;
        m_count++;
      end else if (drp) begin
        if (m_drop < 255) m_drop++;
        m_ovf = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst             = 1'b1;
    trace_en        = 1'b0;
    trace_pkt       = '0;
    tr_if.tr_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(tr_if.tr_valid), 32'h0);
    chk("rst_data", tr_if.tr_data, 32'h0);
    chk("rst_last", 32'(tr_if.tr_last), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    rst = 1'b0;
    cycle();

    // Invalid packets and disabled capture are ignored.
    trace_en  = 1'b1;
    trace_pkt = mk_pkt(32'h1234_5678, 32'h1, 32'h2, 1'b0, 5'd0, 1'b0);
    trace_pkt.trace_rv_i_valid_ip = 1'b0;
    repeat (3) cycle();
    trace_en  = 1'b0;
    trace_pkt.trace_rv_i_valid_ip = 1'b1;
    repeat (3) cycle();
    chk("ignore_count", 32'(fifo_count), 32'h0);

    // Single packet, sink always ready.
    tr_if.tr_ready = 1'b1;
    trace_en  = 1'b1;
    trace_pkt = mk_pkt(32'h8000_0010, 32'h0000_0013, 32'h0, 1'b0, 5'd0, 1'b0);
    cycle();
    trace_en = 1'b0;
    chk("single_b0", tr_if.tr_data, 32'h0000_0001);
    cycle();
    chk("single_b1", tr_if.tr_data, 32'h8000_0010);
    cycle();
    chk("single_b2", tr_if.tr_data, 32'h0000_0013);
    cycle();
    chk("single_b3", tr_if.tr_data, 32'h0);
    chk("single_last", 32'(tr_if.tr_last), 32'h1);
    cycle();
    chk("single_idle", 32'(tr_if.tr_valid), 32'h0);

    // Backpressure on beat 1.
    trace_en  = 1'b1;
    trace_pkt = mk_pkt(32'h8000_0010, 32'h0010_0093, 32'h0, 1'b0, 5'd0, 1'b0);
    cycle();
    trace_en = 1'b0;
    cycle();
    tr_if.tr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", tr_if.tr_data, 32'h8000_0010);
      cycle();
    end
    tr_if.tr_ready = 1'b1;
    repeat (3) cycle();
    chk("bp_done", 32'(tr_if.tr_valid), 32'h0);

    // Overflow: 7 captures into a stalled buffer, then one more after a pop.
    tr_if.tr_ready = 1'b0;
    trace_en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      trace_pkt = mk_pkt(32'h1000_0000 + 32'(k * 4), 32'hA000_0000 + 32'(k), 32'(k), 1'b0, 5'd0, 1'b0);
      cycle();
    end
    trace_en = 1'b0;
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'h1);
    tr_if.tr_ready = 1'b1;
    repeat (4) cycle();
    trace_en  = 1'b1;
    trace_pkt = mk_pkt(32'h2000_0000, 32'h0000_0073, 32'hDEAD_BEEF, 1'b1, 5'd2, 1'b0);
    cycle();
    trace_en = 1'b0;
    repeat (11) cycle();
    chk("ovf_drop_hdr", tr_if.tr_data, 32'h0300_0045);
    repeat (4) cycle();
    chk("ovf_idle", 32'(tr_if.tr_valid), 32'h0);

    // Drop counter saturation: fill, then 300 captures while full.
    tr_if.tr_ready = 1'b0;
    trace_en = 1'b1;
    for (int k = 0; k < 304; k++) begin
      trace_pkt = mk_pkt(32'h3000_0000 + 32'(k), 32'h13, 32'h0, 1'b0, 5'd0, 1'b1);
      cycle();
    end
    trace_en = 1'b0;
    tr_if.tr_ready = 1'b1;
    repeat (16) cycle();
    trace_en  = 1'b1;
    trace_pkt = mk_pkt(32'h4000_0000, 32'h13, 32'h0, 1'b0, 5'd0, 1'b0);
    cycle();
    trace_en = 1'b0;
    chk("sat_hdr", tr_if.tr_data, 32'hFF00_0001);
    repeat (4) cycle();

    // Full buffer with a capture in the same cycle as the head's last beat.
    tr_if.tr_ready = 1'b0;
    trace_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      trace_pkt = mk_pkt(32'h5000_0000 + 32'(k), 32'h5100_0000 + 32'(k), 32'h0, 1'b0, 5'd0, 1'b0);
      cycle();
    end
    trace_en = 1'b0;
    tr_if.tr_ready = 1'b1;
    repeat (3) cycle();
    chk("fullpop_last", 32'(tr_if.tr_last), 32'h1);
    trace_en  = 1'b1;
    trace_pkt = mk_pkt(32'h6000_0000, 32'h6100_0000, 32'h6200_0000, 1'b0, 5'd0, 1'b0);
    cycle();
    trace_en = 1'b0;
    chk("fullpop_count", 32'(fifo_count), 32'd4);
    repeat (12) cycle();
    chk("fullpop_hdr", tr_if.tr_data, 32'h0000_0001);
    repeat (4) cycle();

    // Reset mid-packet with a capture during reset; drop count left nonzero beforehand.
    tr_if.tr_ready = 1'b0;
    trace_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      trace_pkt = mk_pkt(32'h7000_0000 + 32'(k), 32'h13, 32'h0, 1'b1, 5'd7, 1'b0);
      cycle();
    end
    trace_en = 1'b0;
    tr_if.tr_ready = 1'b1;
    repeat (2) cycle();
    rst       = 1'b1;
    trace_en  = 1'b1;
    trace_pkt = mk_pkt(32'h7100_0000, 32'h13, 32'h0, 1'b0, 5'd0, 1'b0);
    cycle();
    rst      = 1'b0;
    trace_en = 1'b0;
    chk("mrst_valid", 32'(tr_if.tr_valid), 32'h0);
    chk("mrst_count", 32'(fifo_count), 32'h0);
    chk("mrst_ovf", 32'(overflow), 32'h0);
    cycle();
    trace_en  = 1'b1;
    trace_pkt = mk_pkt(32'h7200_0000, 32'h13, 32'h0, 1'b0, 5'd0, 1'b0);
    cycle();
    trace_en = 1'b0;
    chk("mrst_hdr", tr_if.tr_data, 32'h0000_0001);
    repeat (5) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
